// File: rtl/uart_receiver_fsm_if.sv
// Receiver-side bundle of the UART core: line and enable in, received word and status out.
interface uart_receiver_fsm_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx_enable;
  logic                 rx_in;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 busy;
  logic                 frame_err;
  logic                 parity_err;

  modport master (
    output rx_enable, rx_in,
    input  rx_data, rx_valid, busy, frame_err, parity_err
  );

  modport slave (
    input  rx_enable, rx_in,
    output rx_data, rx_valid, busy, frame_err, parity_err
  );
endinterface

// File: rtl/uart_receiver_fsm.sv
// Oversampled UART receive FSM: 2-flop synchroniser, start-edge detect, mid-bit sampling, stop check.
// Define RX_PARITY_EN to insert a parity bit between the data bits and the stop bit.
module uart_receiver_fsm #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter bit PARITY_ODD = 1'b0
) (
  input logic                fsm_clk,
  input logic                rst_n,
  uart_receiver_fsm_if.slave rx
);
  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd4;
`ifdef RX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif

  logic                 sync1;
  logic                 sync2;
  logic                 prev;
  logic                 rx_s;
  logic [2:0]           state;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 ferr_q;
  logic                 perr_q;
`ifdef RX_PARITY_EN
  logic                 par_bit;
  logic                 par_mismatch;

  assign par_mismatch = (^shift_reg) ^ PARITY_ODD ^ par_bit;
`else
  logic                 unused_parity_odd;

  assign unused_parity_odd = PARITY_ODD;
`endif

  assign rx_s          = sync2;
  assign rx.rx_data    = data_q;
  assign rx.rx_valid   = valid_q;
  assign rx.busy       = (state != IDLE);
  assign rx.frame_err  = ferr_q;
  assign rx.parity_err = perr_q;

  always_ff @(posedge fsm_clk) begin
    if (!rst_n) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      prev      <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
`ifdef RX_PARITY_EN
      par_bit   <= 1'b0;
`endif
    end else begin
      sync1   <= rx.rx_in;
      sync2   <= sync1;
      prev    <= sync2;
      valid_q <= 1'b0;

      // Disabling discards any partial frame; held outputs are left untouched.
      if (!rx.rx_enable) begin
        state   <= IDLE;
        cnt     <= '0;
        bit_idx <= '0;
      end else begin
        case (state)
          IDLE: begin
            cnt     <= '0;
            bit_idx <= '0;
            if (prev && !rx_s) begin
              state <= START;
            end
          end

          // A start bit that is high again at its mid-point is treated as a glitch.
          START: begin
            if (cnt == CNT_HALF) begin
              cnt <= '0;
              if (!rx_s) begin
                state   <= DATA;
                bit_idx <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          DATA: begin
            if (cnt == CNT_LAST) begin
              cnt       <= '0;
              shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
              bit_idx   <= bit_idx + 1'b1;
              if (bit_idx == IDX_LAST) begin
`ifdef RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

`ifdef RX_PARITY_EN
          PARITY: begin
            if (cnt == CNT_LAST) begin
              cnt     <= '0;
              par_bit <= rx_s;
              state   <= STOP;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
`endif

          STOP: begin
            if (cnt == CNT_LAST) begin
              cnt    <= '0;
              state  <= IDLE;
              ferr_q <= !rx_s;
`ifdef RX_PARITY_EN
              perr_q <= par_mismatch;
              if (rx_s && !par_mismatch) begin
                data_q  <= shift_reg;
                valid_q <= 1'b1;
              end
`else
              if (rx_s) begin
                data_q  <= shift_reg;
                valid_q <= 1'b1;
              end
`endif
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          default: begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_receiver_fsm.sv
// Self-checking bench for uart_receiver_fsm: frame-level scoreboard checked every cycle plus literal pins.
// Works for both the default build and the RX_PARITY_EN build.
module tb_uart_receiver_fsm;
  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 16;
  localparam bit PARITY_ODD = 1'b0;
`ifdef RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
  localparam int LAT    = 171;
`else
  localparam bit PAR_EN = 1'b0;
  localparam int LAT    = 155;
`endif

  typedef struct {
    int         at;
    logic [7:0] data;
    bit         valid;
    bit         ferr;
    bit         perr;
  } ev_t;

  logic fsm_clk = 1'b0;
  logic rst_n   = 1'b0;
  int   cyc     = 0;
  int   checks  = 0;
  int   errors  = 0;
  bit   checking = 1'b0;
  int   valid_count = 0;
  int   last_valid_cyc = -1;

  ev_t        evq[$];
  logic [7:0] m_data = 8'h00;
  bit         m_ferr = 1'b0;
  bit         m_perr = 1'b0;

  uart_receiver_fsm_if #(.DATA_BITS(DATA_BITS)) rx_bus ();

  uart_receiver_fsm #(
    .DATA_BITS (DATA_BITS),
    .OVERSAMPLE(OVERSAMPLE),
    .PARITY_ODD(PARITY_ODD)
  ) dut (
    .fsm_clk(fsm_clk),
    .rst_n  (rst_n),
    .rx     (rx_bus)
  );

  always #5 fsm_clk = ~fsm_clk;

  always @(posedge fsm_clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge fsm_clk);
    #1;
  endtask

  // Drive one frame on the line and schedule what the receiver must report for it.
  task automatic apply_stimulus(input logic [7:0] data, input bit stop, input bit bad_par);
    ev_t e;
    bit  pbit;
    pbit    = (^data) ^ PARITY_ODD ^ bad_par;
    e.at    = cyc + LAT;
    e.data  = data;
    e.ferr  = !stop;
    e.perr  = PAR_EN && bad_par;
    e.valid = stop && !(PAR_EN && bad_par);
    evq.push_back(e);
    rx_bus.rx_in = 1'b0;
    idle_cycles(OVERSAMPLE);
    for (int i = 0; i < DATA_BITS; i++) begin
      rx_bus.rx_in = data[i];
      idle_cycles(OVERSAMPLE);
    end
    if (PAR_EN) begin
      rx_bus.rx_in = pbit;
      idle_cycles(OVERSAMPLE);
    end
    rx_bus.rx_in = stop;
    idle_cycles(OVERSAMPLE);
    rx_bus.rx_in = 1'b1;
  endtask

  // Scoreboard compare: retire due events into the model, then check every output.
  always @(negedge fsm_clk) begin
    bit  exp_valid;
    ev_t e;
    if (checking) begin
      exp_valid = 1'b0;
      if (evq.size() > 0 && evq[0].at == cyc) begin
        e = evq.pop_front();
        exp_valid = e.valid;
        m_ferr = e.ferr;
        m_perr = e.perr;
        if (e.valid) m_data = e.data;
      end
      check_output("rx_valid", 32'(rx_bus.rx_valid), 32'(exp_valid));
      check_output("rx_data", 32'(rx_bus.rx_data), 32'(m_data));
      check_output("frame_err", 32'(rx_bus.frame_err), 32'(m_ferr));
      check_output("parity_err", 32'(rx_bus.parity_err), 32'(m_perr));
      if (rx_bus.rx_valid === 1'b1) begin
        valid_count++;
        last_valid_cyc = cyc;
      end
    end
  end

  initial begin
    int         f;
    ev_t        e;
    logic [7:0] extra [4];
    extra[0] = 8'h00;
    extra[1] = 8'h80;
    extra[2] = 8'h7E;
    extra[3] = 8'hC3;

    rx_bus.rx_in     = 1'b1;
    rx_bus.rx_enable = 1'b1;
    rst_n            = 1'b0;
    idle_cycles(1);
    checking = 1'b1;
    idle_cycles(2);
    check_output("reset_busy", 32'(rx_bus.busy), 32'd0);
    check_output("reset_valid", 32'(rx_bus.rx_valid), 32'd0);
    check_output("reset_data", 32'(rx_bus.rx_data), 32'd0);
    check_output("reset_ferr", 32'(rx_bus.frame_err), 32'd0);
    rst_n = 1'b1;
    idle_cycles(10);
    check_output("idle_busy", 32'(rx_bus.busy), 32'd0);
    check_output("idle_data", 32'(rx_bus.rx_data), 32'd0);

    $display("[TB] good frame 0xA5");
    f = cyc;
    apply_stimulus(8'hA5, 1'b1, 1'b0);
    idle_cycles(20);
    check_output("a5_data", 32'(rx_bus.rx_data), 32'h0000_00A5);
    check_output("a5_count", 32'(valid_count), 32'd1);
    check_output("a5_latency", 32'(last_valid_cyc - f), PAR_EN ? 32'd171 : 32'd155);
    check_output("a5_ferr", 32'(rx_bus.frame_err), 32'd0);

    $display("[TB] start glitch");
    rx_bus.rx_in = 1'b0;
    idle_cycles(4);
    check_output("glitch_busy_high", 32'(rx_bus.busy), 32'd1);
    rx_bus.rx_in = 1'b1;
    idle_cycles(20);
    check_output("glitch_busy_low", 32'(rx_bus.busy), 32'd0);
    check_output("glitch_count", 32'(valid_count), 32'd1);
    check_output("glitch_data", 32'(rx_bus.rx_data), 32'h0000_00A5);

    $display("[TB] bad stop 0x3C then good 0x0F");
    apply_stimulus(8'h3C, 1'b0, 1'b0);
    idle_cycles(20);
    check_output("3c_ferr", 32'(rx_bus.frame_err), 32'd1);
    check_output("3c_data", 32'(rx_bus.rx_data), 32'h0000_00A5);
    check_output("3c_count", 32'(valid_count), 32'd1);
    apply_stimulus(8'h0F, 1'b1, 1'b0);
    idle_cycles(20);
    check_output("0f_ferr", 32'(rx_bus.frame_err), 32'd0);
    check_output("0f_data", 32'(rx_bus.rx_data), 32'h0000_000F);
    check_output("0f_count", 32'(valid_count), 32'd2);

    $display("[TB] line break then 0x55");
    e.at = cyc + LAT; e.data = 8'h00; e.valid = 1'b0; e.ferr = 1'b1; e.perr = 1'b0;
    evq.push_back(e);
    rx_bus.rx_in = 1'b0;
    idle_cycles(300);
    rx_bus.rx_in = 1'b1;
    idle_cycles(20);
    check_output("break_ferr", 32'(rx_bus.frame_err), 32'd1);
    check_output("break_busy", 32'(rx_bus.busy), 32'd0);
    apply_stimulus(8'h55, 1'b1, 1'b0);
    idle_cycles(20);
    check_output("55_data", 32'(rx_bus.rx_data), 32'h0000_0055);
    check_output("55_ferr", 32'(rx_bus.frame_err), 32'd0);
    check_output("55_count", 32'(valid_count), 32'd3);

    $display("[TB] enable dropped during data bit 3");
    rx_bus.rx_in = 1'b0;
    idle_cycles(70);
    check_output("abort_busy_before", 32'(rx_bus.busy), 32'd1);
    rx_bus.rx_enable = 1'b0;
    idle_cycles(1);
    check_output("abort_busy_after", 32'(rx_bus.busy), 32'd0);
    rx_bus.rx_in = 1'b1;
    idle_cycles(5);
    rx_bus.rx_enable = 1'b1;
    idle_cycles(200);
    check_output("abort_count", 32'(valid_count), 32'd3);
    check_output("abort_data", 32'(rx_bus.rx_data), 32'h0000_0055);
    apply_stimulus(8'hFF, 1'b1, 1'b0);
    idle_cycles(20);
    check_output("ff_data", 32'(rx_bus.rx_data), 32'h0000_00FF);
    check_output("ff_count", 32'(valid_count), 32'd4);

`ifdef RX_PARITY_EN
    $display("[TB] parity error on 0x01");
    apply_stimulus(8'h01, 1'b1, 1'b1);
    idle_cycles(20);
    check_output("par_err", 32'(rx_bus.parity_err), 32'd1);
    check_output("par_data", 32'(rx_bus.rx_data), 32'h0000_00FF);
    check_output("par_count", 32'(valid_count), 32'd4);
`else
    check_output("par_tied", 32'(rx_bus.parity_err), 32'd0);
`endif

    $display("[TB] extra back-to-back frames");
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(extra[i], 1'b1, 1'b0);
    end
    idle_cycles(20);
    check_output("extra_data", 32'(rx_bus.rx_data), 32'h0000_00C3);
    check_output("extra_pending", 32'(evq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
